seq_fsm_prog_moore: RTL and testbench

// Run-time programmable, table-driven Moore FSM: next-state and output tables are held in flops and written through a config port.

---
 rtl/seq_fsm_prog_pkg.sv | 21 ++
 rtl/seq_fsm_prog_tbl.sv | 72 +++++++
 rtl/seq_fsm_prog_moore.sv | 112 +++++++++++
 tb/tb_seq_fsm_prog_moore.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_fsm_prog_pkg.sv
// Shared sizing helpers for the programmable table-driven Moore sequencer.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package seq_fsm_prog_pkg;

  localparam int DEF_NSTATES = 6;
  localparam int DEF_IBITS   = 2;
  localparam int DEF_OBITS   = 2;
  localparam int NENTRIES    = DEF_NSTATES * (2 ** DEF_IBITS);

  // Config data must carry either a state code or an output word.
  function automatic int cfg_w(input int sbits, input int obits);
    return (sbits > obits) ? sbits : obits;
  endfunction

  // Number of next-state entries: one per (state, input) pair.
  function automatic int nentries(input int nstates, input int ibits);
    return nstates * (1 << ibits);
  endfunction

endpackage

// File: rtl/seq_fsm_prog_tbl.sv
// Flop-based next-state and output tables with one write port and two read ports.
// Latency: writes commit on posedge; reads are combinational (0 cycles).
// Backpressure: none; writes to state indices >= NSTATES are dropped.
//
// Ports: clk, rst_n (async active-low, loads reset contents),
//        nxt_wen_i/out_wen_i + wr_st_i/wr_in_i/nxt_dat_i/out_dat_i (write port),
//        rd_st_i/rd_in_i -> rd_nxt_o (next-state lookup), rd_st_i -> rd_out_o (output lookup).
module seq_fsm_prog_tbl
  import seq_fsm_prog_pkg::*;
#(
  parameter int NSTATES  = 6,
  parameter int IBITS    = 2,
  parameter int OBITS    = 2,
  parameter int SBITS    = $clog2(NSTATES),
  parameter int RESET_ST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nxt_wen_i,
  input  logic             out_wen_i,
  input  logic [SBITS-1:0] wr_st_i,
  input  logic [IBITS-1:0] wr_in_i,
  input  logic [SBITS-1:0] nxt_dat_i,
  input  logic [OBITS-1:0] out_dat_i,
  input  logic [SBITS-1:0] rd_st_i,
  input  logic [IBITS-1:0] rd_in_i,
  output logic [SBITS-1:0] rd_nxt_o,
  output logic [OBITS-1:0] rd_out_o
);

  localparam int NENT = nentries(NSTATES, IBITS);
  localparam int AW   = SBITS + IBITS;
  localparam logic [SBITS:0]   NST    = (SBITS+1)'(NSTATES);
  localparam logic [SBITS-1:0] RST_ST = SBITS'(RESET_ST);

  logic [SBITS-1:0] nxt_q [NENT];
  logic [OBITS-1:0] out_q [NSTATES];

  // {state, input} is exactly state*2**IBITS + input, so the flat table
  // needs no multiplier and its index width matches $clog2(NENT).
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          wr_st_ok;

  assign wr_idx   = {wr_st_i, wr_in_i};
  assign rd_idx   = {rd_st_i, rd_in_i};
  assign wr_st_ok = ({1'b0, wr_st_i} < NST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        nxt_q[i] <= RST_ST;
      end
      for (int i = 0; i < NSTATES; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      if (nxt_wen_i && wr_st_ok) begin
        nxt_q[wr_idx] <= nxt_dat_i;
      end
      if (out_wen_i && wr_st_ok) begin
        out_q[wr_st_i] <= out_dat_i;
      end
    end
  end

  // The read state always comes from a legal state register, so the
  // indices stay within the populated rows.
  assign rd_nxt_o = nxt_q[rd_idx];
  assign rd_out_o = out_q[rd_st_i];

endmodule

// File: rtl/seq_fsm_prog_moore.sv
// Run-time programmable table-driven Moore FSM with hold, illegal-state trap and change strobe.
// Latency: in_ -> state 1 cycle; state -> out 0 cycles (combinational table lookup).
// Backpressure: en=0 holds state; config writes are always accepted (out-of-range ones dropped).
//
// Ports: clk, reset (async active-low), en, in_,
//        cfg_nxt_wen/cfg_out_wen/cfg_st/cfg_in/cfg_data (table write port),
//        state, out, changed (1-cycle pulse on state change), err (sticky illegal-next flag).
module seq_fsm_prog_moore
  import seq_fsm_prog_pkg::*;
#(
  parameter  int NSTATES  = 6,
  parameter  int IBITS    = 2,
  parameter  int OBITS    = 2,
  parameter  int SBITS    = $clog2(NSTATES),
  parameter  int RESET_ST = 0,
  localparam int DW       = cfg_w(SBITS, OBITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [IBITS-1:0] in_,
  input  logic             cfg_nxt_wen,
  input  logic             cfg_out_wen,
  input  logic [SBITS-1:0] cfg_st,
  input  logic [IBITS-1:0] cfg_in,
  input  logic [DW-1:0]    cfg_data,
  output logic [SBITS-1:0] state,
  output logic [OBITS-1:0] out,
  output logic             changed,
  output logic             err
);

  if (NSTATES < 2) begin : g_chk_nstates
    $error("seq_fsm_prog_moore: NSTATES must be >= 2");
  end
  if (RESET_ST < 0 || RESET_ST >= NSTATES) begin : g_chk_reset_st
    $error("seq_fsm_prog_moore: RESET_ST must be < NSTATES");
  end
  if (IBITS < 1) begin : g_chk_ibits
    $error("seq_fsm_prog_moore: IBITS must be >= 1");
  end
  if (OBITS < 1) begin : g_chk_obits
    $error("seq_fsm_prog_moore: OBITS must be >= 1");
  end

  localparam logic [SBITS:0]   NST    = (SBITS+1)'(NSTATES);
  localparam logic [SBITS-1:0] RST_ST = SBITS'(RESET_ST);

  logic [SBITS-1:0] state_q, state_d;
  logic             changed_q, changed_d;
  logic             err_q, err_d;
  logic [SBITS-1:0] tbl_nxt;
  logic [OBITS-1:0] tbl_out;

  seq_fsm_prog_tbl #(
    .NSTATES  (NSTATES),
    .IBITS    (IBITS),
    .OBITS    (OBITS),
    .SBITS    (SBITS),
    .RESET_ST (RESET_ST)
  ) u_tbl (
    .clk       (clk),
    .rst_n     (reset),
    .nxt_wen_i (cfg_nxt_wen),
    .out_wen_i (cfg_out_wen),
    .wr_st_i   (cfg_st),
    .wr_in_i   (cfg_in),
    .nxt_dat_i (cfg_data[SBITS-1:0]),
    .out_dat_i (cfg_data[OBITS-1:0]),
    .rd_st_i   (state_q),
    .rd_in_i   (in_),
    .rd_nxt_o  (tbl_nxt),
    .rd_out_o  (tbl_out)
  );

  // The table read sees the pre-write contents on a write edge, so a
  // freshly written entry is only used from the following edge on.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (en) begin
      if ({1'b0, tbl_nxt} >= NST) begin
        // Illegal code: recover to the reset state and latch the error.
        state_d = RST_ST;
        err_d   = 1'b1;
      end else begin
        state_d = tbl_nxt;
      end
    end
    // Compare against the state actually taken, so a trap out of
    // RESET_ST or a self-loop does not strobe.
    changed_d = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RST_ST;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  assign state   = state_q;
  assign out     = tbl_out;
  assign changed = changed_q;
  assign err     = err_q;

endmodule

// File: tb/tb_seq_fsm_prog_moore.sv
// Self-checking bench for seq_fsm_prog_moore with a reference model and expected-value queue.
// Latency: each driven cycle pushes one expectation, popped and compared 1 ns after the edge.
// Backpressure: n/a.
module tb_seq_fsm_prog_moore;

  localparam int NS = 6;
  localparam int IB = 2;
  localparam int OB = 2;
  localparam int SB = 3;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [IB-1:0] in_;
  logic          cfg_nxt_wen;
  logic          cfg_out_wen;
  logic [SB-1:0] cfg_st;
  logic [IB-1:0] cfg_in;
  logic [DW-1:0] cfg_data;
  logic [SB-1:0] state;
  logic [OB-1:0] out;
  logic          changed;
  logic          err;

  always #5 clk = ~clk;

  seq_fsm_prog_moore #(
    .NSTATES  (NS),
    .IBITS    (IB),
    .OBITS    (OB),
    .RESET_ST (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .in_         (in_),
    .cfg_nxt_wen (cfg_nxt_wen),
    .cfg_out_wen (cfg_out_wen),
    .cfg_st      (cfg_st),
    .cfg_in      (cfg_in),
    .cfg_data    (cfg_data),
    .state       (state),
    .out         (out),
    .changed     (changed),
    .err         (err)
  );

  typedef struct packed {
    logic [SB-1:0] st;
    logic [OB-1:0] o;
    logic          chg;
    logic          er;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";

  // Reference model state
  logic [SB-1:0] m_nxt [NS][4];
  logic [OB-1:0] m_out [NS];
  logic [SB-1:0] m_state;
  logic          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < 4; i++) m_nxt[s][i] = '0;
      m_out[s] = '0;
    end
    m_state = '0;
    m_err   = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("state", 32'(state), 32'd0);
    check("out", 32'(out), 32'd0);
    check("changed", 32'(changed), 32'd0);
    check("err", 32'(err), 32'd0);
  endtask

  // One clock cycle: drive at negedge, predict, compare after posedge.
  task automatic cyc(input logic e, input logic [1:0] i, input logic nw, input logic ow,
                     input logic [2:0] st, input logic [1:0] ci, input logic [2:0] d);
    logic [SB-1:0] nx;
    exp_t          x;
    en = e; in_ = i; cfg_nxt_wen = nw; cfg_out_wen = ow;
    cfg_st = st; cfg_in = ci; cfg_data = d;
    nx = m_state;
    if (e) begin
      nx = m_nxt[m_state][i];
      if (int'(nx) >= NS) begin
        nx    = '0;
        m_err = 1'b1;
      end
    end
    x.chg   = (nx != m_state);
    m_state = nx;
    if (nw && int'(st) < NS) m_nxt[st][ci] = d;
    if (ow && int'(st) < NS) m_out[st] = d[1:0];
    x.st = m_state;
    x.o  = m_out[m_state];
    x.er = m_err;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check("state", 32'(state), 32'(x.st));
    check("out", 32'(out), 32'(x.o));
    check("changed", 32'(changed), 32'(x.chg));
    check("err", 32'(err), 32'(x.er));
    @(negedge clk);
    cfg_nxt_wen = 1'b0;
    cfg_out_wen = 1'b0;
  endtask

  task automatic step(input logic [1:0] i);
    cyc(1'b1, i, 1'b0, 1'b0, 3'd0, 2'd0, 3'd0);
  endtask

  task automatic hold(input logic [1:0] i);
    cyc(1'b0, i, 1'b0, 1'b0, 3'd0, 2'd0, 3'd0);
  endtask

  task automatic wr_row(input logic [2:0] st, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, st, 2'd0, a);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, st, 2'd1, b);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, st, 2'd2, c);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, st, 2'd3, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b0; in_ = '0; cfg_nxt_wen = 1'b0; cfg_out_wen = 1'b0;
    cfg_st = '0; cfg_in = '0; cfg_data = '0;
    model_reset();
    #12;
    phase = "reset";
    check_reset_vals();
    @(negedge clk);
    reset = 1'b1;

    // 1: unprogrammed tables keep the FSM parked in A
    phase = "t1_unprog";
    for (int k = 0; k < 3; k++) step(2'b01);

    // 2: program tables (D entry 00 + D output written in the same cycle)
    phase = "t2_load";
    wr_row(3'd0, 3'd0, 3'd1, 3'd0, 3'd4);
    wr_row(3'd1, 3'd2, 3'd1, 3'd0, 3'd4);
    wr_row(3'd2, 3'd0, 3'd3, 3'd0, 3'd4);
    cyc(1'b0, 2'd0, 1'b1, 1'b1, 3'd3, 2'd0, 3'b010);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 3'd3, 2'd1, 3'd1);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 3'd3, 2'd2, 3'd0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 3'd3, 2'd3, 3'd4);
    wr_row(3'd4, 3'd5, 3'd5, 3'd0, 3'd4);
    wr_row(3'd5, 3'd0, 3'd0, 3'd0, 3'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 3'd4, 2'd0, 3'b001);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 3'd5, 2'd0, 3'b001);
    // out-of-range writes must be dropped without aliasing
    cyc(1'b0, 2'd0, 1'b1, 1'b1, 3'd6, 2'd1, 3'b011);
    cyc(1'b0, 2'd0, 1'b1, 1'b1, 3'd7, 2'd1, 3'b011);
    phase = "t2_walk";
    step(2'b01);
    step(2'b00);
    step(2'b01);

    // 3: self-loop in E, then E->F->A
    phase = "t3_loop";
    step(2'b11);
    step(2'b11);
    step(2'b11);
    step(2'b00);
    step(2'b10);

    // 4: hold with en=0
    phase = "t4_hold";
    for (int k = 0; k < 3; k++) hold(2'b01);
    step(2'b01);
    step(2'b10);

    // 5: illegal next state, sticky err, output write while resident
    phase = "t5_illegal";
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 2'd1, 3'd7);
    step(2'b01);
    step(2'b00);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 2'd0, 3'b011);
    // write-then-use: this edge still reads the old (illegal) entry
    cyc(1'b1, 2'b01, 1'b1, 1'b0, 3'd0, 2'd1, 3'd1);
    step(2'b01);

    // 6: asynchronous reset while in D
    phase = "t6_areset";
    step(2'b00);
    step(2'b01);
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    step(2'b01);
    step(2'b01);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
